// File: rtl/ate_blk_fmt.sv
// ate_blk_fmt: raster-to-8x8-block reformatter with a double-banked 8-line strip buffer.
// Defining ATE_BLK_FMT_SOB_EN adds the sob and blk_idx outputs.
//
// state | meaning
// IDLE  | no strip being read; waits for the read bank to fill, lets the last beat drain
// READ  | emitting a strip in block order, one pixel per advance
module ate_blk_fmt #(
  parameter int IMG_W = 48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_pix,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_pix,
  input  logic       out_ready,
`ifdef ATE_BLK_FMT_SOB_EN
  output logic       sob,
  output logic [2:0] blk_idx,
`endif
  output logic       strip_end
);

  localparam int NBLK    = IMG_W / 8;
  localparam int BANK_SZ = 8 * IMG_W;
  localparam int DEPTH   = 2 * BANK_SZ;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = $clog2(IMG_W);
  localparam int BW      = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic {IDLE, READ} state_t;

  logic [7:0]    mem [DEPTH];

  logic [CW-1:0] wr_col;
  logic [2:0]    wr_row;
  logic          wr_bank;
  logic [1:0]    bank_full;
  logic          wr_en;
  logic          wr_last;
  logic [AW-1:0] wr_addr;

  state_t        state, state_nxt;
  logic [2:0]    rd_c, rd_c_nxt;
  logic [2:0]    rd_r, rd_r_nxt;
  logic [BW-1:0] rd_b, rd_b_nxt;
  logic          rd_bank, rd_bank_nxt;
  logic          rd_last;
  logic          rd_clr;
  logic          adv;
  logic          load;
  logic [AW-1:0] rd_addr;
  logic          out_valid_nxt;
  logic [7:0]    out_pix_nxt;
  logic          strip_end_nxt;
`ifdef ATE_BLK_FMT_SOB_EN
  logic          sob_nxt;
  logic [2:0]    blk_idx_nxt;
`endif

  // Write side: raster order into the bank the writer currently owns.
  assign in_ready = !bank_full[wr_bank];
  assign wr_en    = in_valid && in_ready;
  assign wr_last  = (wr_row == 3'd7) && (wr_col == CW'(IMG_W - 1));
  assign wr_addr  = (wr_bank ? AW'(BANK_SZ) : '0) + AW'(wr_row) * AW'(IMG_W) + AW'(wr_col);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_pix;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_col  <= '0;
      wr_row  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_en) begin
      if (wr_last) begin
        wr_col  <= '0;
        wr_row  <= '0;
        wr_bank <= !wr_bank;
      end else if (wr_col == CW'(IMG_W - 1)) begin
        wr_col <= '0;
        wr_row <= wr_row + 3'd1;
      end else begin
        wr_col <= wr_col + CW'(1);
      end
    end
  end

  // Set and clear never hit the same bank on one edge, so per-bit priority is moot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_full <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en && wr_last && (wr_bank == 1'(i)))
          bank_full[i] <= 1'b1;
        else if (rd_clr && (rd_bank == 1'(i)))
          bank_full[i] <= 1'b0;
      end
    end
  end

  // Read side: block order, raster order inside each 8x8 block.
  assign adv     = !out_valid || out_ready;
  assign rd_last = (rd_b == BW'(NBLK - 1)) && (rd_r == 3'd7) && (rd_c == 3'd7);
  assign rd_addr = (rd_bank ? AW'(BANK_SZ) : '0) + AW'(rd_r) * AW'(IMG_W)
                 + AW'({rd_b, 3'b000}) + AW'(rd_c);

  always_comb begin
    state_nxt     = state;
    rd_c_nxt      = rd_c;
    rd_r_nxt      = rd_r;
    rd_b_nxt      = rd_b;
    rd_bank_nxt   = rd_bank;
    out_valid_nxt = out_valid;
    out_pix_nxt   = out_pix;
    strip_end_nxt = strip_end;
`ifdef ATE_BLK_FMT_SOB_EN
    sob_nxt       = sob;
    blk_idx_nxt   = blk_idx;
`endif
    load          = 1'b0;
    rd_clr        = 1'b0;

    case (state)
      IDLE: begin
        if (adv) begin
          if (bank_full[rd_bank]) begin
            load      = 1'b1;
            state_nxt = READ;
          end else begin
            out_valid_nxt = 1'b0;
            strip_end_nxt = 1'b0;
`ifdef ATE_BLK_FMT_SOB_EN
            sob_nxt       = 1'b0;
`endif
          end
        end
      end
      READ: load = adv;
    endcase

    if (load) begin
      out_valid_nxt = 1'b1;
      out_pix_nxt   = mem[rd_addr];
      strip_end_nxt = rd_last;
`ifdef ATE_BLK_FMT_SOB_EN
      sob_nxt       = (rd_r == 3'd0) && (rd_c == 3'd0);
      blk_idx_nxt   = 3'(rd_b);
`endif
      if (rd_last) begin
        rd_clr      = 1'b1;
        rd_c_nxt    = '0;
        rd_r_nxt    = '0;
        rd_b_nxt    = '0;
        rd_bank_nxt = !rd_bank;
        // Chain straight into the other bank when it is already waiting.
        state_nxt   = bank_full[!rd_bank] ? READ : IDLE;
      end else if (rd_c == 3'd7) begin
        rd_c_nxt = '0;
        if (rd_r == 3'd7) begin
          rd_r_nxt = '0;
          rd_b_nxt = rd_b + BW'(1);
        end else begin
          rd_r_nxt = rd_r + 3'd1;
        end
      end else begin
        rd_c_nxt = rd_c + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rd_c      <= '0;
      rd_r      <= '0;
      rd_b      <= '0;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
      out_pix   <= '0;
      strip_end <= 1'b0;
`ifdef ATE_BLK_FMT_SOB_EN
      sob       <= 1'b0;
      blk_idx   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      rd_c      <= rd_c_nxt;
      rd_r      <= rd_r_nxt;
      rd_b      <= rd_b_nxt;
      rd_bank   <= rd_bank_nxt;
      out_valid <= out_valid_nxt;
      out_pix   <= out_pix_nxt;
      strip_end <= strip_end_nxt;
`ifdef ATE_BLK_FMT_SOB_EN
      sob       <= sob_nxt;
      blk_idx   <= blk_idx_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ate_blk_fmt.sv
// Scoreboard bench for ate_blk_fmt: the driver queues the block-ordered strip it just
// completed, a forked monitor pops and compares each output beat.
module tb_ate_blk_fmt;
  localparam int IMG_W = 48;
  localparam int NBLK  = IMG_W / 8;
  localparam int SPIX  = 8 * IMG_W;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_pix;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_pix;
  logic       out_ready;
  logic       strip_end;
`ifdef ATE_BLK_FMT_SOB_EN
  logic       sob;
  logic [2:0] blk_idx;
`endif

  typedef struct packed {
    logic [7:0] pix;
    logic       se;
    logic       sob;
    logic [2:0] blk;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_wait = 0;
  int   gaps = 0;
  bit   track_gap = 1'b0;
  bit   seen_valid = 1'b0;
  bit   cap_en = 1'b0;
  int   n_cap = 0;
  logic [7:0] cap_pix [SPIX];
  logic       cap_se  [SPIX];
  logic       cap_sob [SPIX];
  logic [2:0] cap_blk [SPIX];

  ate_blk_fmt #(.IMG_W(IMG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pix(in_pix), .in_ready(in_ready),
    .out_valid(out_valid), .out_pix(out_pix), .out_ready(out_ready),
`ifdef ATE_BLK_FMT_SOB_EN
    .sob(sob), .blk_idx(blk_idx),
`endif
    .strip_end(strip_end)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  function automatic logic [7:0] pixf(input int seed, input int r, input int c);
    return 8'((r * IMG_W + c + seed * 37) & 255);
  endfunction

  task automatic push_strip(input int seed);
    exp_t e;
    for (int b = 0; b < NBLK; b++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          e.pix = pixf(seed, r, b * 8 + c);
          e.se  = (b == NBLK - 1) && (r == 7) && (c == 7);
          e.sob = (r == 0) && (c == 0);
          e.blk = 3'(b);
          exp_q.push_back(e);
        end
  endtask

  // Sends npix raster pixels; queues the expected block stream just before the final accept.
  task automatic send_strip(input int seed, input int npix, input bit push);
    logic rdy;
    int   k;
    for (int i = 0; i < npix; i++) begin
      in_valid = 1'b1;
      in_pix   = pixf(seed, i / IMG_W, i % IMG_W);
      k = 0;
      forever begin
        @(negedge clk);
        rdy = in_ready;
        if (rdy && push && (i == SPIX - 1)) push_strip(seed);
        @(posedge clk);
        #1;
        if (rdy) break;
        n_wait++;
        k++;
        if (k > 5000) begin
          check("in_ready_timeout", in_ready, 1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 5000 && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    check({"drain_", name}, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic       pv = 1'b0, pr = 1'b1, pse = 1'b0, psob = 1'b0;
    logic [7:0] pp = '0;
    logic [2:0] pblk = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (pv && !pr) begin
        check("stall_valid", out_valid, 1);
        check("stall_pix", out_pix, pp);
        check("stall_strip_end", strip_end, pse);
`ifdef ATE_BLK_FMT_SOB_EN
        check("stall_sob", sob, psob);
        check("stall_blk_idx", blk_idx, pblk);
`endif
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_pix", out_pix, e.pix);
          check("strip_end", strip_end, e.se);
`ifdef ATE_BLK_FMT_SOB_EN
          check("sob", sob, e.sob);
          check("blk_idx", blk_idx, e.blk);
`endif
          if (cap_en && n_cap < SPIX) begin
            cap_pix[n_cap] = out_pix;
            cap_se[n_cap]  = strip_end;
`ifdef ATE_BLK_FMT_SOB_EN
            cap_sob[n_cap] = sob;
            cap_blk[n_cap] = blk_idx;
`else
            cap_sob[n_cap] = 1'b0;
            cap_blk[n_cap] = '0;
`endif
            n_cap++;
          end
        end
      end
      if (track_gap) begin
        if (out_valid) seen_valid = 1'b1;
        else if (seen_valid && exp_q.size() > 0) gaps++;
      end
      pv   = out_valid;
      pr   = out_ready;
      pp   = out_pix;
      pse  = strip_end;
`ifdef ATE_BLK_FMT_SOB_EN
      psob = sob;
      pblk = blk_idx;
`endif
    end
  endtask

  initial begin
    logic [7:0] want_head [10];
    int         n_se, early, found, n_sob;
    want_head = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd48, 8'd49};

    reset = 1'b1; in_valid = 1'b0; in_pix = '0; out_ready = 1'b1;
    fork monitor(); join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pix", out_pix, 0);
    check("rst_strip_end", strip_end, 0);
`ifdef ATE_BLK_FMT_SOB_EN
    check("rst_sob", sob, 0);
    check("rst_blk_idx", blk_idx, 0);
`endif
    @(posedge clk); #1 reset = 1'b0;

    // Single strip, hand-checked ordering and first-output latency
    cap_en = 1'b1; n_cap = 0;
    send_strip(0, SPIX, 1);
    @(negedge clk);
    check("lat_before", out_valid, 0);
    @(negedge clk);
    check("lat_first", out_valid, 1);
    wait_drain("strip1");
    cap_en = 1'b0;
    check("cap_count", n_cap, SPIX);
    for (int k = 0; k < 10; k++) check($sformatf("head_pix%0d", k), cap_pix[k], want_head[k]);
    check("pix64", cap_pix[64], 8);
    check("pix384", cap_pix[SPIX-1], 127);
    check("se384", cap_se[SPIX-1], 1);
    n_se = 0;
    for (int k = 0; k < SPIX; k++) if (cap_se[k]) n_se++;
    check("se_count", n_se, 1);
`ifdef ATE_BLK_FMT_SOB_EN
    n_sob = 0;
    for (int k = 0; k < SPIX; k++) if (cap_sob[k]) n_sob++;
    check("sob_count", n_sob, 6);
    for (int b = 0; b < NBLK; b++) begin
      check($sformatf("sob_at%0d", b * 64 + 1), cap_sob[b * 64], 1);
      check($sformatf("blk_at%0d", b * 64 + 1), cap_blk[b * 64], b);
    end
`else
    n_sob = 0;
`endif

    // Three strips streamed back to back
    n_wait = 0; gaps = 0; seen_valid = 1'b0; track_gap = 1'b1;
    send_strip(10, SPIX, 1);
    send_strip(11, SPIX, 1);
    send_strip(12, SPIX, 1);
    wait_drain("stream3");
    track_gap = 1'b0;
    check("stream_in_waits", n_wait, 0);
    check("stream_out_gaps", gaps, 0);

    // Both banks filled while the consumer stalls
    out_ready = 1'b0; n_wait = 0;
    send_strip(0, SPIX, 1);
    send_strip(21, SPIX, 1);
    check("fill2_in_waits", n_wait, 0);
    in_valid = 1'b1; in_pix = 8'hAA;
    repeat (4) begin
      @(negedge clk);
      check("full_in_ready", in_ready, 0);
      check("full_out_valid", out_valid, 1);
      check("full_out_pix", out_pix, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    early = 0; found = 0;
    for (int k = 0; k < 1000 && found == 0; k++) begin
      @(negedge clk);
      if (out_valid && strip_end) begin
        check("in_ready_at_last_out", in_ready, 1);
        found = 1;
      end else if (in_ready) begin
        early++;
      end
    end
    check("strip0_end_seen", found, 1);
    check("in_ready_early", early, 0);
    wait_drain("fill2");

    // Consumer stall pattern 1,0,0,1 throughout a strip
    send_strip(30, SPIX, 1);
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) begin
      out_ready = (i % 4 == 1 || i % 4 == 2) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain("stall_pat");

    // Reset in the middle of a strip, then a fresh strip
    send_strip(40, 200, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1 reset = 1'b0;
    send_strip(41, SPIX, 1);
    wait_drain("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
